// File: rtl/apb_demux_nslv.sv
// APB3 1-to-N demux: decodes BASE/MASK windows, replays on one slave; decode-miss and timeout errors.
// Latency 3 cycles + slave waits (decode miss: 1); upstream is held off by pready until the slave finishes or the watchdog fires.
module apb_demux_nslv #(
    parameter int                          NUM_SLV     = 4,
    parameter int                          P_ADDR_W    = 32,
    parameter int                          P_DATA_W    = 32,
    parameter int                          P_STRB_W    = P_DATA_W / 8,
    parameter logic [NUM_SLV*P_ADDR_W-1:0] SLV_BASE    = {32'h3000_0000, 32'h2000_0000,
                                                          32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*P_ADDR_W-1:0] SLV_MASK    = {4{32'hF000_0000}},
    parameter int                          TIMEOUT_CYC = 256,
    parameter logic [P_DATA_W-1:0]         ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [P_ADDR_W-1:0]         paddr,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [P_DATA_W-1:0]         pwdata,
    input  logic [P_STRB_W-1:0]         pwstrb,
    output logic                        pready,
    output logic [P_DATA_W-1:0]         prdata,
    output logic                        pslverr,
    output logic [NUM_SLV-1:0]          m_psel,
    output logic                        m_penable,
    output logic [P_ADDR_W-1:0]         m_paddr,
    output logic                        m_pwrite,
    output logic [P_DATA_W-1:0]         m_pwdata,
    output logic [P_STRB_W-1:0]         m_pwstrb,
    input  logic [NUM_SLV-1:0]          m_pready,
    input  logic [NUM_SLV*P_DATA_W-1:0] m_prdata,
    input  logic [NUM_SLV-1:0]          m_pslverr,
    output logic                        dec_err,
    output logic                        tmo_err,
    output logic [7:0]                  err_cnt
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx_q, idx_nxt;
    logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  slv_rdy, slv_err, tmo_hit, accept;
    logic [P_DATA_W-1:0]   slv_dat;

    logic                  pready_nxt, pslverr_nxt, m_penable_nxt, m_pwrite_nxt;
    logic                  dec_err_nxt, tmo_err_nxt;
    logic [P_DATA_W-1:0]   prdata_nxt, m_pwdata_nxt;
    logic [NUM_SLV-1:0]    m_psel_nxt;
    logic [P_ADDR_W-1:0]   m_paddr_nxt;
    logic [P_STRB_W-1:0]   m_pwstrb_nxt;
    logic [7:0]            err_cnt_nxt;

    // Scan high-to-low so the lowest matching window is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((paddr & SLV_MASK[i*P_ADDR_W +: P_ADDR_W]) == SLV_BASE[i*P_ADDR_W +: P_ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign accept  = psel && !penable;
    assign slv_rdy = m_pready[idx_q];
    assign slv_err = m_pslverr[idx_q];
    assign slv_dat = m_prdata[idx_q*P_DATA_W +: P_DATA_W];
    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = hit ? SETUP : RESP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (slv_rdy || tmo_hit) state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pready_nxt    = 1'b0;
        prdata_nxt    = '0;
        pslverr_nxt   = 1'b0;
        m_psel_nxt    = '0;
        m_penable_nxt = 1'b0;
        m_paddr_nxt   = m_paddr;
        m_pwrite_nxt  = m_pwrite;
        m_pwdata_nxt  = m_pwdata;
        m_pwstrb_nxt  = m_pwstrb;
        dec_err_nxt   = 1'b0;
        tmo_err_nxt   = 1'b0;
        err_cnt_nxt   = err_cnt;
        idx_nxt       = idx_q;
        tmo_cnt_nxt   = '0;
        case (state)
            IDLE: if (accept) begin
                m_paddr_nxt  = paddr;
                m_pwrite_nxt = pwrite;
                m_pwdata_nxt = pwdata;
                m_pwstrb_nxt = pwstrb;
                idx_nxt      = hit_idx;
                if (hit) begin
                    m_psel_nxt = NUM_SLV'(1) << hit_idx;
                end else begin
                    pready_nxt  = 1'b1;
                    pslverr_nxt = 1'b1;
                    prdata_nxt  = ERR_DATA;
                    dec_err_nxt = 1'b1;
                    err_cnt_nxt = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                end
            end
            SETUP: begin
                m_psel_nxt    = m_psel;
                m_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (slv_rdy) begin
                    pready_nxt  = 1'b1;
                    prdata_nxt  = slv_dat;
                    pslverr_nxt = slv_err;
                end else if (tmo_hit) begin
                    pready_nxt  = 1'b1;
                    prdata_nxt  = ERR_DATA;
                    pslverr_nxt = 1'b1;
                    tmo_err_nxt = 1'b1;
                    err_cnt_nxt = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                end else begin
                    m_psel_nxt    = m_psel;
                    m_penable_nxt = 1'b1;
                    tmo_cnt_nxt   = tmo_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_paddr   <= '0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
            m_pwstrb  <= '0;
            dec_err   <= 1'b0;
            tmo_err   <= 1'b0;
            err_cnt   <= 8'd0;
            idx_q     <= '0;
            tmo_cnt   <= '0;
        end else begin
            pready    <= pready_nxt;
            prdata    <= prdata_nxt;
            pslverr   <= pslverr_nxt;
            m_psel    <= m_psel_nxt;
            m_penable <= m_penable_nxt;
            m_paddr   <= m_paddr_nxt;
            m_pwrite  <= m_pwrite_nxt;
            m_pwdata  <= m_pwdata_nxt;
            m_pwstrb  <= m_pwstrb_nxt;
            dec_err   <= dec_err_nxt;
            tmo_err   <= tmo_err_nxt;
            err_cnt   <= err_cnt_nxt;
            idx_q     <= idx_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_apb_demux_nslv.sv
// Directed bench for apb_demux_nslv: four slaves, slave0/slave2 windows overlap, 16-cycle watchdog.
module tb_apb_demux_nslv;

    localparam int NUM_SLV = 4;
    localparam logic [127:0] BASE = {32'h3000_0000, 32'h4000_0000, 32'h1000_0000, 32'h4000_0000};
    localparam logic [127:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000};

    logic         pclk, presetn;
    logic [31:0]  paddr, pwdata, prdata, m_paddr, m_pwdata;
    logic         psel, penable, pwrite, pready, pslverr;
    logic [3:0]   pwstrb, m_pwstrb, m_psel, m_pready, m_pslverr;
    logic         m_penable, m_pwrite, dec_err, tmo_err;
    logic [127:0] m_prdata;
    logic [7:0]   err_cnt;

    int           checks = 0;
    int           failures = 0;
    int           wait_states = 0;
    int           acc_cnt;
    logic [3:0]   hang = 4'b0000;
    logic [3:0]   slv_err_cfg = 4'b0000;

    apb_demux_nslv #(
        .NUM_SLV(NUM_SLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(16)
    ) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb), .m_pready(m_pready),
        .m_prdata(m_prdata), .m_pslverr(m_pslverr), .dec_err(dec_err), .tmo_err(tmo_err),
        .err_cnt(err_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave model: selected slave answers after wait_states ACCESS cycles; unselected slaves shout ready/error.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn)       acc_cnt <= 0;
        else if (m_penable) acc_cnt <= acc_cnt + 1;
        else                acc_cnt <= 0;
    end

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
        assign m_pready[g]           = m_psel[g] ? (m_penable && !hang[g] && acc_cnt == wait_states) : 1'b1;
        assign m_pslverr[g]          = m_psel[g] ? slv_err_cfg[g] : 1'b1;
        assign m_prdata[g*32 +: 32]  = {16'hA5A5, 16'(g)};
    end

    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, output int lat, output logic [31:0] rd, output logic er);
        @(negedge pclk);
        paddr = addr; pwrite = wr; pwdata = wd; pwstrb = st; psel = 1'b1; penable = 1'b0;
        lat = -1; rd = 'x; er = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge pclk);
            penable = 1'b1;
            if (pready) begin
                lat = c; rd = prdata; er = pslverr;
                break;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        checks++;
        if ({pready, pslverr, m_penable, m_pwrite, dec_err, tmo_err} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b exp 000000", {pready, pslverr, m_penable, m_pwrite, dec_err, tmo_err});
        end
        checks++;
        if (m_psel !== 4'b0) begin failures++; $display("FAIL reset_psel: got %b exp 0000", m_psel); end
        checks++;
        if (prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata: got %h exp 0", prdata); end
        checks++;
        if (err_cnt !== 8'h0) begin failures++; $display("FAIL reset_err_cnt: got %h exp 0", err_cnt); end
        checks++;
        if ({m_paddr, m_pwdata, m_pwstrb} !== 68'h0) begin
            failures++; $display("FAIL reset_bus: got %h %h %h exp 0", m_paddr, m_pwdata, m_pwstrb);
        end
        presetn = 1'b1;
    endtask

    task automatic test_read_zero_wait();
        wait_states = 0;
        @(negedge pclk);
        paddr = 32'h1000_0004; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge pclk);
        checks++;
        if ({m_psel, m_penable, pready} !== 6'b0010_0_0) begin
            failures++; $display("FAIL rd_t1: psel/pen/rdy got %b exp 001000", {m_psel, m_penable, pready});
        end
        penable = 1'b1;
        @(negedge pclk);
        checks++;
        if ({m_psel, m_penable, pready} !== 6'b0010_1_0 || m_paddr !== 32'h1000_0004 || m_pwrite !== 1'b0) begin
            failures++; $display("FAIL rd_t2: got %b addr %h wr %b exp 001010 10000004 0",
                                 {m_psel, m_penable, pready}, m_paddr, m_pwrite);
        end
        @(negedge pclk);
        checks++;
        if (pready !== 1'b1 || prdata !== 32'hA5A5_0001 || pslverr !== 1'b0) begin
            failures++; $display("FAIL rd_t3: rdy %b data %h err %b exp 1 a5a50001 0", pready, prdata, pslverr);
        end
        checks++;
        if ({m_psel, m_penable} !== 5'b0) begin failures++; $display("FAIL rd_t3_drop: got %b exp 00000", {m_psel, m_penable}); end
        go_idle();
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0) begin
            failures++; $display("FAIL rd_t4_idle: rdy %b data %h exp 0 0", pready, prdata);
        end
    endtask

    task automatic test_write_wait();
        int lat, pen_cycles, bad;
        logic er;
        wait_states = 3; lat = -1; pen_cycles = 0; bad = 0; er = 1'bx;
        @(negedge pclk);
        paddr = 32'h3000_0008; pwrite = 1'b1; pwdata = 32'h1234_5678; pwstrb = 4'b0011;
        psel = 1'b1; penable = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge pclk);
            penable = 1'b1;
            if (m_penable) begin
                pen_cycles++;
                if (m_psel !== 4'b1000 || m_pwdata !== 32'h1234_5678 || m_pwstrb !== 4'b0011 ||
                    m_pwrite !== 1'b1 || m_paddr !== 32'h3000_0008) bad++;
            end
            if (pready) begin lat = c; er = pslverr; break; end
        end
        checks++;
        if (lat != 6) begin failures++; $display("FAIL wr_latency: got %0d exp 6", lat); end
        checks++;
        if (pen_cycles != 4) begin failures++; $display("FAIL wr_access_cycles: got %0d exp 4", pen_cycles); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wr_bus_stable: bad cycles %0d exp 0", bad); end
        checks++;
        if (er !== 1'b0) begin failures++; $display("FAIL wr_pslverr: got %b exp 0", er); end
        go_idle();
        wait_states = 0;
    endtask

    task automatic test_decode_miss();
        int lat; logic [31:0] rd; logic er;
        do_xfer(32'h7000_0000, 1'b0, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (lat != 1 || rd !== 32'hDEAD_BEEF || er !== 1'b1) begin
            failures++; $display("FAIL miss_resp: lat %0d data %h err %b exp 1 deadbeef 1", lat, rd, er);
        end
        checks++;
        if ({dec_err, tmo_err, m_psel} !== 6'b10_0000) begin
            failures++; $display("FAIL miss_flags: dec/tmo/psel got %b exp 100000", {dec_err, tmo_err, m_psel});
        end
        checks++;
        if (err_cnt !== 8'd1) begin failures++; $display("FAIL miss_err_cnt: got %0d exp 1", err_cnt); end
        go_idle();
        checks++;
        if ({dec_err, pready} !== 2'b00 || prdata !== 32'h0) begin
            failures++; $display("FAIL miss_pulse_end: dec/rdy %b data %h exp 00 0", {dec_err, pready}, prdata);
        end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd; logic er;
        hang = 4'b0100;
        do_xfer(32'h4100_0000, 1'b0, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (lat != 18 || rd !== 32'hDEAD_BEEF || er !== 1'b1) begin
            failures++; $display("FAIL tmo_resp: lat %0d data %h err %b exp 18 deadbeef 1", lat, rd, er);
        end
        checks++;
        if ({dec_err, tmo_err, m_psel, m_penable} !== 7'b01_0000_0) begin
            failures++; $display("FAIL tmo_flags: dec/tmo/psel/pen got %b exp 0100000", {dec_err, tmo_err, m_psel, m_penable});
        end
        checks++;
        if (err_cnt !== 8'd2) begin failures++; $display("FAIL tmo_err_cnt: got %0d exp 2", err_cnt); end
        hang = 4'b0000;
        go_idle();
        checks++;
        if (tmo_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse_end: got %b exp 0", tmo_err); end
        do_xfer(32'h4000_0020, 1'b0, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (lat != 3 || rd !== 32'hA5A5_0000 || er !== 1'b0) begin
            failures++; $display("FAIL tmo_recover: lat %0d data %h err %b exp 3 a5a50000 0", lat, rd, er);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic [31:0] rd1, rd2; logic er1, er2;
        slv_err_cfg = 4'b1000;
        do_xfer(32'h1000_0010, 1'b1, 32'hCAFE_0001, 4'hF, lat1, rd1, er1);
        do_xfer(32'h3000_0000, 1'b0, 32'h0, 4'h0, lat2, rd2, er2);
        checks++;
        if (lat1 != 3 || lat2 != 3) begin failures++; $display("FAIL b2b_latency: got %0d %0d exp 3 3", lat1, lat2); end
        checks++;
        if (er1 !== 1'b0 || rd2 !== 32'hA5A5_0003 || er2 !== 1'b1) begin
            failures++; $display("FAIL b2b_resp: err1 %b data2 %h err2 %b exp 0 a5a50003 1", er1, rd2, er2);
        end
        checks++;
        if (err_cnt !== 8'd2) begin failures++; $display("FAIL b2b_err_cnt: got %0d exp 2", err_cnt); end
        slv_err_cfg = 4'b0000;
        go_idle();
    endtask

    task automatic test_overlap_saturate();
        int lat; logic [31:0] rd; logic er;
        @(negedge pclk);
        paddr = 32'h4000_0010; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge pclk);
        checks++;
        if (m_psel !== 4'b0001) begin failures++; $display("FAIL overlap_psel: got %b exp 0001", m_psel); end
        penable = 1'b1;
        rd = 'x;
        for (int c = 0; c < 10; c++) begin
            @(negedge pclk);
            if (pready) begin rd = prdata; break; end
        end
        checks++;
        if (rd !== 32'hA5A5_0000) begin failures++; $display("FAIL overlap_data: got %h exp a5a50000", rd); end
        go_idle();
        for (int k = 0; k < 250; k++) do_xfer(32'h7000_0000 | 32'(k), 1'b0, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (err_cnt !== 8'hFC) begin failures++; $display("FAIL sat_mid: got %h exp fc", err_cnt); end
        for (int k = 0; k < 50; k++) do_xfer(32'h7000_0100 | 32'(k), 1'b0, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (err_cnt !== 8'hFF || lat != 1 || er !== 1'b1) begin
            failures++; $display("FAIL sat_hold: cnt %h lat %0d err %b exp ff 1 1", err_cnt, lat, er);
        end
        go_idle();
    endtask

    task automatic test_reset_in_access();
        int lat; logic [31:0] rd; logic er;
        hang = 4'b0100;
        @(negedge pclk);
        paddr = 32'h4100_0000; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        repeat (3) begin @(negedge pclk); penable = 1'b1; end
        checks++;
        if ({m_psel, m_penable} !== 5'b0100_1) begin failures++; $display("FAIL rst_pre_access: got %b exp 01001", {m_psel, m_penable}); end
        #2 presetn = 1'b0;
        #1;
        checks++;
        if ({m_psel, m_penable, pready} !== 6'b0 || err_cnt !== 8'h0) begin
            failures++; $display("FAIL rst_async: psel/pen/rdy %b cnt %h exp 000000 00", {m_psel, m_penable, pready}, err_cnt);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1; hang = 4'b0000;
        do_xfer(32'h1000_0004, 1'b0, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (lat != 3 || rd !== 32'hA5A5_0001 || er !== 1'b0) begin
            failures++; $display("FAIL rst_recover: lat %0d data %h err %b exp 3 a5a50001 0", lat, rd, er);
        end
        go_idle();
    endtask

    initial begin
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pwstrb = 4'h0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_decode_miss();
        test_timeout();
        test_back_to_back();
        test_overlap_saturate();
        test_reset_in_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", checks, failures);
        $fatal(1);
    end

endmodule
